mini_cpu_core: RTL and testbench

Parametrised single-cycle accumulator CPU core, the next generation of the board's 4-bit two-register teaching CPU. It widens the datapath and program counter by parameter, replaces the free-running divided clock with a clock-enable step input, and adds a HALT instruction and an output-valid strobe. It sits between an external asynchronous program ROM and the board I/O: switches on `in_port`, LEDs/7-segment drivers on `out_port`.

---
 rtl/mini_cpu_core.sv | 126 ++++++++++++
 tb/tb_mini_cpu_core.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mini_cpu_core.sv
// Single-cycle accumulator CPU: fetch from an asynchronous ROM at PC, execute on each enabled edge.
// Registers A/B/OUT, carry flag, sticky HALT and a one-step output-valid strobe.
module mini_cpu_core #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned PC_WIDTH   = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  output logic [PC_WIDTH-1:0]   prog_addr,
  input  logic [DATA_WIDTH+3:0] prog_data,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  out_valid,
  output logic                  halted,
  output logic                  carry,
  output logic [DATA_WIDTH-1:0] reg_a,
  output logic [DATA_WIDTH-1:0] reg_b
);

  typedef enum logic [3:0] {
    OpAddA  = 4'b0000,
    OpMovAB = 4'b0001,
    OpInA   = 4'b0010,
    OpMovAI = 4'b0011,
    OpMovBA = 4'b0100,
    OpAddB  = 4'b0101,
    OpInB   = 4'b0110,
    OpMovBI = 4'b0111,
    OpOutB  = 4'b1001,
    OpOutI  = 4'b1011,
    OpHalt  = 4'b1100,
    OpJnc   = 4'b1110,
    OpJmp   = 4'b1111
  } op_e;

  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  c_q, c_d, h_q, h_d, valid_q, valid_d;

  op_e                   op;
  logic [DATA_WIDTH-1:0] imm;
  logic [PC_WIDTH-1:0]   imm_pc;
  logic [DATA_WIDTH:0]   sum_a, sum_b;

  assign op     = op_e'(prog_data[DATA_WIDTH+3:DATA_WIDTH]);
  assign imm    = prog_data[DATA_WIDTH-1:0];
  assign imm_pc = imm[PC_WIDTH-1:0];
  assign sum_a  = {1'b0, a_q} + {1'b0, imm};
  assign sum_b  = {1'b0, b_q} + {1'b0, imm};

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    pc_d    = pc_q;
    c_d     = c_q;
    h_d     = h_q;
    valid_d = 1'b0;
    if (en && !h_q) begin
      // Every executed instruction rewrites carry; only ADDs can set it.
      c_d  = 1'b0;
      pc_d = pc_q + PC_WIDTH'(1);
      case (op)
        OpAddA: begin
          a_d = sum_a[DATA_WIDTH-1:0];
          c_d = sum_a[DATA_WIDTH];
        end
        OpMovAB: a_d = b_q;
        OpInA:   a_d = in_port;
        OpMovAI: a_d = imm;
        OpMovBA: b_d = a_q;
        OpAddB: begin
          b_d = sum_b[DATA_WIDTH-1:0];
          c_d = sum_b[DATA_WIDTH];
        end
        OpInB:   b_d = in_port;
        OpMovBI: b_d = imm;
        OpOutB: begin
          out_d   = b_q;
          valid_d = 1'b1;
        end
        OpOutI: begin
          out_d   = imm;
          valid_d = 1'b1;
        end
        OpHalt: begin
          h_d  = 1'b1;
          pc_d = pc_q;
        end
        OpJnc:   if (!c_q) pc_d = imm_pc;
        OpJmp:   pc_d = imm_pc;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      pc_q    <= '0;
      c_q     <= 1'b0;
      h_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      pc_q    <= pc_d;
      c_q     <= c_d;
      h_q     <= h_d;
      valid_q <= valid_d;
    end
  end

  assign prog_addr = pc_q;
  assign out_port  = out_q;
  assign out_valid = valid_q;
  assign halted    = h_q;
  assign carry     = c_q;
  assign reg_a     = a_q;
  assign reg_b     = b_q;

endmodule

// File: tb/tb_mini_cpu_core.sv
// Bench for mini_cpu_core at 4/4 and 8/6 widths: directed programs plus random ROMs,
// every cycle compared against an instruction-level reference model.
module tb_mini_cpu_core;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic en  = 1'b0;
  always #5 CLK = ~CLK;

  logic [3:0]  pa4, in4, out4, a4, b4;
  logic [7:0]  pd4;
  logic        ov4, h4, c4;
  logic [5:0]  pa8;
  logic [11:0] pd8;
  logic [7:0]  in8, out8, a8, b8;
  logic        ov8, h8, c8;

  logic [7:0]  rom4 [16];
  logic [11:0] rom8 [64];
  assign pd4 = rom4[pa4];
  assign pd8 = rom8[pa8];

  mini_cpu_core #(.DATA_WIDTH(4), .PC_WIDTH(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .en(en), .prog_addr(pa4), .prog_data(pd4), .in_port(in4),
    .out_port(out4), .out_valid(ov4), .halted(h4), .carry(c4), .reg_a(a4), .reg_b(b4)
  );

  mini_cpu_core #(.DATA_WIDTH(8), .PC_WIDTH(6)) u_dut8 (
    .CLK(CLK), .RST(RST), .en(en), .prog_addr(pa8), .prog_data(pd8), .in_port(in8),
    .out_port(out8), .out_valid(ov8), .halted(h8), .carry(c8), .reg_a(a8), .reg_b(b8)
  );

  typedef struct packed {
    logic [15:0] a, b, o, pc;
    logic        c, h, v;
  } mstate_t;

  mstate_t m4, m8;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One architectural step, straight from the instruction-set rules.
  function automatic mstate_t mstep(input mstate_t s, input int dw, input int pw,
                                    input int ins, input int inp, input logic rst,
                                    input logic step);
    mstate_t n;
    int m, pm, op, im, sum;
    n = s;
    if (rst) return '0;
    n.v = 1'b0;
    if (!step || s.h) return n;
    m   = 1 << dw;
    pm  = 1 << pw;
    op  = (ins >> dw) & 15;
    im  = ins & (m - 1);
    n.c = 1'b0;
    n.pc = 16'((int'(s.pc) + 1) % pm);
    case (op)
      0: begin sum = int'(s.a) + im; n.a = 16'(sum % m); n.c = (sum >= m); end
      1: n.a = s.b;
      2: n.a = 16'(inp % m);
      3: n.a = 16'(im);
      4: n.b = s.a;
      5: begin sum = int'(s.b) + im; n.b = 16'(sum % m); n.c = (sum >= m); end
      6: n.b = 16'(inp % m);
      7: n.b = 16'(im);
      9: begin n.o = s.b; n.v = 1'b1; end
      11: begin n.o = 16'(im); n.v = 1'b1; end
      12: begin n.h = 1'b1; n.pc = s.pc; end
      14: if (!s.c) n.pc = 16'(im % pm);
      15: n.pc = 16'(im % pm);
      default: ;
    endcase
    return n;
  endfunction

  task automatic compare_all();
    check("pc4", pa4, m4.pc);   check("a4", a4, m4.a);     check("b4", b4, m4.b);
    check("out4", out4, m4.o);  check("ov4", ov4, m4.v);   check("h4", h4, m4.h);
    check("c4", c4, m4.c);
    check("pc8", pa8, m8.pc);   check("a8", a8, m8.a);     check("b8", b8, m8.b);
    check("out8", out8, m8.o);  check("ov8", ov8, m8.v);   check("h8", h8, m8.h);
    check("c8", c8, m8.c);
  endtask

  task automatic cycle(input logic en_v, input logic rst_v);
    en  = en_v;
    RST = rst_v;
    @(posedge CLK);
    m4 = mstep(m4, 4, 4, int'(rom4[m4.pc[3:0]]), int'(in4), rst_v, en_v);
    m8 = mstep(m8, 8, 6, int'(rom8[m8.pc[5:0]]), int'(in8), rst_v, en_v);
    #1;
    compare_all();
  endtask

  initial begin
    m4  = '0;
    m8  = '0;
    in4 = 4'hA;
    in8 = 8'h5C;
    for (int i = 0; i < 16; i++) rom4[i] = 8'h80;
    for (int i = 0; i < 64; i++) rom8[i] = 12'h800;

    // Program 1: arithmetic, JNC fall-through, IN/OUT, HALT at 6.
    rom4[0] = 8'h33; rom4[1] = 8'h05; rom4[2] = 8'h09; rom4[3] = 8'hE0;
    rom4[4] = 8'h60; rom4[5] = 8'h90; rom4[6] = 8'hC0;
    rom8[0] = 12'hFC5; rom8[5] = 12'h301; rom8[6] = 12'h0FF;
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    check("rst_pc4", pa4, 0); check("rst_a4", a4, 0); check("rst_h4", h4, 0);
    cycle(1'b1, 1'b0);
    check("jmp8_pc", pa8, 6'h05);
    cycle(1'b1, 1'b0);
    check("add_a8", a4, 8);   check("add_c0", c4, 0);
    cycle(1'b1, 1'b0);
    check("add_wrap_a", a4, 1); check("add_wrap_c", c4, 1);
    check("add8_a", a8, 0);   check("add8_c", c8, 1);
    cycle(1'b1, 1'b0);
    check("jnc_fall_pc", pa4, 4);
    cycle(1'b1, 1'b0);
    check("in_b", b4, 4'hA);
    cycle(1'b1, 1'b0);
    check("out_b", out4, 4'hA); check("out_valid", ov4, 1);
    cycle(1'b1, 1'b0);
    check("halted", h4, 1); check("halt_pc", pa4, 6); check("halt_ov", ov4, 0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
    check("halt_hold_pc", pa4, 6);
    cycle(1'b1, 1'b1);
    check("rst2_h", h4, 0); check("rst2_pc", pa4, 0); check("rst2_out", out4, 0);

    // Program 2: carry into JNC, pulse width under en gaps, JNC taken.
    rom4[0] = 8'h3F; rom4[1] = 8'h01; rom4[2] = 8'hE0; rom4[3] = 8'hB5;
    rom4[4] = 8'h90; rom4[5] = 8'h40; rom4[6] = 8'hE0;
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("carry_a0", a4, 0); check("carry_c1", c4, 1);
    cycle(1'b1, 1'b0);
    check("jnc_c1_pc", pa4, 3);
    cycle(1'b1, 1'b0);
    check("outi_port", out4, 5); check("outi_v", ov4, 1);
    cycle(1'b0, 1'b0);
    check("hold_v0", ov4, 0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    check("outb_v", ov4, 1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("jnc_taken_pc", pa4, 0);

    // Program 3: PC wrap over NOPs, then held steps.
    for (int i = 0; i < 16; i++) rom4[i] = 8'h80;
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0);
    check("wrap_pc", pa4, 0);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
    check("en0_pc", pa4, 1);

    // Random programs, inputs, step enables and occasional resets.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) begin
        rom4[i] = 8'($urandom);
        if (rom4[i][7:4] == 4'hC && $urandom_range(0, 3) != 0) rom4[i] = 8'h80;
      end
      for (int i = 0; i < 64; i++) begin
        rom8[i] = 12'($urandom);
        if (rom8[i][11:8] == 4'hC && $urandom_range(0, 7) != 0) rom8[i] = 12'hA00;
      end
      cycle(1'b1, 1'b1);
      for (int i = 0; i < 200; i++) begin
        in4 = 4'($urandom);
        in8 = 8'($urandom);
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
